data_mem_arbiter: RTL and testbench

//  Round-robin arbiter sharing one 256x8 data-memory port among N_CORES cores.

---
 rtl/data_mem_pkg.sv | 19 +
 rtl/data_mem_arbiter_rr_pick.sv | 29 ++
 rtl/data_mem_arbiter.sv | 116 +++++++++++
 tb/tb_data_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package data_mem_pkg;

    localparam int N_CORES = 8;
    localparam int AW      = 8;
    localparam int DW      = 8;
    localparam int CW      = $clog2(N_CORES);

    typedef enum logic {INIT, RUN} arb_state_t;

    // Each core owns a 2**(AW-CW)-byte window; offsets wrap inside that window.
    function automatic logic [AW-1:0] phys_addr(input logic [CW-1:0] core,
                                                input logic [AW-1:0] addr);
        logic [AW-1:0] mask;
        mask = AW'((1 << (AW - CW)) - 1);
        return (AW'(core) << (AW - CW)) | (addr & mask);
    endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr_i.
module rr_pick #(
    parameter int N = 8
) (
    input  logic [N-1:0]         eligible_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic                 valid_o,
    output logic [$clog2(N)-1:0] idx_o
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] cand;

    // N is a power of two, so the IW-bit sum wraps modulo N on its own.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = ptr_i + IW'(i);
            if (!valid_o && eligible_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one async-read data-memory port among N_CORES
// cores, with an optional post-reset clear of the whole memory.
module data_mem_arbiter #(
    parameter int N_CORES        = data_mem_pkg::N_CORES,
    parameter int AW             = data_mem_pkg::AW,
    parameter int DW             = data_mem_pkg::DW,
    parameter int WINDOWED       = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CORES-1:0]    req,
    input  logic [N_CORES-1:0]    we,
    input  logic [N_CORES*AW-1:0] addr,
    input  logic [N_CORES*DW-1:0] wdata,
    output logic [N_CORES-1:0]    ack,
    output logic [DW-1:0]         rdata,
    output logic                  init_done,
    output logic [AW-1:0]         mem_addr,
    output logic                  mem_we,
    output logic [DW-1:0]         mem_wdata,
    input  logic [DW-1:0]         mem_rdata
);

    import data_mem_pkg::*;

    localparam int IDXW = $clog2(N_CORES);

    arb_state_t           state_q;
    logic [AW-1:0]        clr_cnt_q;
    logic [AW-1:0]        mem_addr_q;
    logic [IDXW-1:0]      rr_ptr_q;
    logic [N_CORES-1:0]   ack_q;
    logic [N_CORES-1:0]   ack_d;
    logic [DW-1:0]        rdata_q;
    logic                 init_done_q;

    logic [N_CORES-1:0]   eligible;
    logic                 win_valid;
    logic [IDXW-1:0]      win_idx;
    logic                 grant;
    logic [AW-1:0]        win_addr;
    logic [AW-1:0]        win_phys;
    logic [DW-1:0]        win_wdata;
    logic                 win_we;

    // The core acked this cycle is masked so a lone requester gets every other slot.
    assign eligible = req & ~ack_q;

    rr_pick #(.N(N_CORES)) u_pick (
        .eligible_i (eligible),
        .ptr_i      (rr_ptr_q),
        .valid_o    (win_valid),
        .idx_o      (win_idx)
    );

    always_comb begin
        win_addr  = addr[int'(win_idx)*AW +: AW];
        win_wdata = wdata[int'(win_idx)*DW +: DW];
        win_we    = we[win_idx];
        win_phys  = (WINDOWED != 0) ? phys_addr(win_idx, win_addr) : win_addr;
        grant     = (state_q == RUN) && win_valid;

        ack_d = '0;
        if (grant) ack_d[win_idx] = 1'b1;

        mem_addr  = mem_addr_q;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (state_q == INIT) begin
            mem_addr = clr_cnt_q;
            mem_we   = reset;
        end else if (grant) begin
            mem_addr  = win_phys;
            mem_we    = win_we & reset;
            mem_wdata = win_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? INIT : RUN;
            clr_cnt_q   <= '0;
            mem_addr_q  <= '0;
            rr_ptr_q    <= '0;
            ack_q       <= '0;
            rdata_q     <= '0;
            init_done_q <= (CLEAR_ON_RESET == 0);
        end else begin
            ack_q <= ack_d;
            case (state_q)
                INIT: begin
                    clr_cnt_q  <= clr_cnt_q + 1'b1;
                    mem_addr_q <= clr_cnt_q;
                    if (clr_cnt_q == '1) begin
                        state_q     <= RUN;
                        init_done_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (grant) begin
                        rr_ptr_q   <= win_idx + 1'b1;
                        rdata_q    <= mem_rdata;
                        mem_addr_q <= win_phys;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural model of the arbitration rules and a shadow memory.
module tb_data_mem_arbiter;

    localparam int N = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset = 1'b1;
    logic [N-1:0]   req, we, ack;
    logic [N*8-1:0] addr, wdata;
    logic [7:0]     rdata, mem_addr, mem_wdata, mem_rdata;
    logic           init_done, mem_we;

    logic [N-1:0]   nreq, nwe, nack;
    logic [N*8-1:0] naddr, nwdata;
    logic [7:0]     nrdata, nmem_addr, nmem_wdata, nmem_rdata;
    logic           ninit_done, nmem_we;

    logic           prefill = 1'b0;
    logic [7:0]     mem  [256];
    logic [7:0]     nmem [256];

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    data_mem_arbiter #(.N_CORES(8), .AW(8), .DW(8), .WINDOWED(1), .CLEAR_ON_RESET(1)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .init_done(init_done), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    data_mem_arbiter #(.N_CORES(8), .AW(8), .DW(8), .WINDOWED(0), .CLEAR_ON_RESET(0)) dut_nw (
        .clk(clk), .reset(reset), .req(nreq), .we(nwe), .addr(naddr), .wdata(nwdata),
        .ack(nack), .rdata(nrdata), .init_done(ninit_done), .mem_addr(nmem_addr),
        .mem_we(nmem_we), .mem_wdata(nmem_wdata), .mem_rdata(nmem_rdata)
    );

    function automatic logic [7:0] fill_val(int unsigned i);
        return 8'((i * 7 + 13) | 1);
    endfunction

    assign mem_rdata  = mem[mem_addr];
    assign nmem_rdata = nmem[nmem_addr];

    always @(posedge clk) begin
        if (prefill) begin
            for (int unsigned i = 0; i < 256; i++) begin
                mem[i]  <= fill_val(i);
                nmem[i] <= fill_val(i);
            end
        end else begin
            if (mem_we)  mem[mem_addr]   <= mem_wdata;
            if (nmem_we) nmem[nmem_addr] <= nmem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_core(input int unsigned c, input logic r, input logic w,
                            input logic [7:0] a, input logic [7:0] d);
        req[c] = r;
        we[c]  = w;
        addr[c*8 +: 8]  = a;
        wdata[c*8 +: 8] = d;
    endtask

    task automatic nset_core(input int unsigned c, input logic r, input logic w,
                             input logic [7:0] a, input logic [7:0] d);
        nreq[c] = r;
        nwe[c]  = w;
        naddr[c*8 +: 8]  = a;
        nwdata[c*8 +: 8] = d;
    endtask

    task automatic wait_init();
        int unsigned k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!init_done && k < 400);
        check("init_done_seen", 32'(init_done), 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        req = '0; we = '0; nreq = '0; nwe = '0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        wait_init();
    endtask

    task automatic single_access(input int unsigned c, input logic w, input logic [7:0] a,
                                 input logic [7:0] d, input logic [7:0] exp_phys,
                                 input logic [7:0] exp_rd, input string tag);
        @(posedge clk);
        #1 set_core(c, 1'b1, w, a, d);
        @(negedge clk);
        check({tag, "_mem_addr"}, mem_addr, exp_phys);
        check({tag, "_mem_we"}, 32'(mem_we), 32'(w));
        @(negedge clk);
        check({tag, "_ack"}, ack, 32'(1) << c);
        check({tag, "_rdata"}, rdata, exp_rd);
        @(posedge clk);
        #1 req[c] = 1'b0;
    endtask

    initial begin
        #200ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [7:0]  ref_mem [256];
    bit          pend [N];
    int unsigned k_done, we_cnt, init_ack, nz, ptr_m, w, phys, load;
    logic [7:0]  exp_ack, exp_rd, a;
    bit          found;

    initial begin
        req = '0; we = '0; addr = '0; wdata = '0;
        nreq = '0; nwe = '0; naddr = '0; nwdata = '0;
        #2 reset = 1'b0;

        // Reset state and post-reset clear
        @(posedge clk);
        #1 prefill = 1'b1;
        @(posedge clk);
        #1 prefill = 1'b0;
        @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_rdata", rdata, 0);
        check("rst_init_done", 32'(init_done), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_nw_init_done", 32'(ninit_done), 1);
        check("prefill_nonzero", mem[8'h45], fill_val(8'h45));
        @(posedge clk);
        #1 reset = 1'b1;
        k_done = 0; we_cnt = 0; init_ack = 0;
        for (int unsigned k = 1; k <= 400 && k_done == 0; k++) begin
            @(negedge clk);
            if (init_done) k_done = k;
            else begin
                if (mem_we) we_cnt++;
                if (ack != 0) init_ack++;
            end
        end
        check("init_done_cycle", k_done, 257);
        check("clear_we_cycles", we_cnt, 256);
        check("ack_during_init", init_ack, 0);
        nz = 0;
        for (int unsigned i = 0; i < 256; i++) if (mem[i] != 8'h00) nz++;
        check("mem_cleared", nz, 0);

        // Windowed write/read and window wrap
        single_access(2, 1'b1, 8'h05, 8'hA5, 8'h45, 8'h00, "t2_wr");
        check("t2_mem45", mem[8'h45], 8'hA5);
        single_access(2, 1'b0, 8'h05, 8'h00, 8'h45, 8'hA5, "t2_rd");
        single_access(3, 1'b1, 8'hFF, 8'h5A, 8'h7F, 8'h00, "wrap");
        check("wrap_mem7f", mem[8'h7F], 8'h5A);

        // All cores requesting: strict rotation from pointer 0
        do_reset();
        @(posedge clk);
        #1 for (int unsigned c = 0; c < N; c++) set_core(c, 1'b1, 1'b0, 8'(c), 8'h00);
        for (int unsigned j = 0; j <= 16; j++) begin
            @(negedge clk);
            check("t3_ack", ack, (j == 0) ? 0 : (32'(1) << ((j - 1) % 8)));
        end
        @(posedge clk);
        #1 req = '0;
        repeat (3) @(posedge clk);

        // Single requester served every other cycle; pointer then sits at 7
        #1 set_core(6, 1'b1, 1'b0, 8'h11, 8'h00);
        for (int unsigned j = 0; j < 10; j++) begin
            @(negedge clk);
            check("t4_ack", ack, (j % 2 == 1) ? 32'h40 : 0);
        end
        @(posedge clk);
        #1;
        req[6] = 1'b0;
        set_core(0, 1'b1, 1'b0, 8'h01, 8'h00);
        set_core(5, 1'b1, 1'b0, 8'h02, 8'h00);
        set_core(7, 1'b1, 1'b0, 8'h03, 8'h00);
        for (int unsigned j = 0; j < 4; j++) begin
            @(negedge clk);
            case (j)
                0: check("t4_ptr_ack0", ack, 0);
                1: check("t4_ptr_ack1", ack, 32'h80);
                2: check("t4_ptr_ack2", ack, 32'h01);
                default: check("t4_ptr_ack3", ack, 32'h20);
            endcase
        end
        @(posedge clk);
        #1 req = '0;
        repeat (3) @(posedge clk);

        // Reset landing on a grant cycle
        #1 set_core(3, 1'b1, 1'b1, 8'h02, 8'h77);
        @(negedge clk);
        check("t5_grant_we", 32'(mem_we), 1);
        check("t5_grant_addr", mem_addr, 8'h62);
        reset = 1'b0;
        #1;
        check("t5_we_in_reset", 32'(mem_we), 0);
        @(negedge clk);
        check("t5_ack_lost", ack, 0);
        check("t5_rdata_reset", rdata, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        set_core(6, 1'b1, 1'b0, 8'h03, 8'h00);
        k_done = 0;
        for (int unsigned k = 1; k <= 400 && k_done == 0; k++) begin
            @(negedge clk);
            if (ack != 0) k_done = k;
        end
        check("t5_first_ack_cycle", k_done, 258);
        check("t5_first_ack", ack, 32'h08);
        check("t5_first_rdata", rdata, 0);
        @(negedge clk);
        check("t5_second_ack", ack, 32'h40);
        check("t5_mem62", mem[8'h62], 8'h77);
        @(posedge clk);
        #1 req = '0;

        // Flat addressing: same-cycle write then read of one byte
        do_reset();
        check("t6_init_done", 32'(ninit_done), 1);
        @(posedge clk);
        #1;
        nset_core(0, 1'b1, 1'b1, 8'h10, 8'h3C);
        nset_core(7, 1'b1, 1'b0, 8'h10, 8'h00);
        @(negedge clk);
        check("t6_mem_addr0", nmem_addr, 8'h10);
        check("t6_mem_we0", 32'(nmem_we), 1);
        check("t6_mem_wdata0", nmem_wdata, 8'h3C);
        @(negedge clk);
        check("t6_ack0", nack, 32'h01);
        check("t6_rdata0", nrdata, fill_val(8'h10));
        check("t6_mem_addr7", nmem_addr, 8'h10);
        check("t6_mem_we7", 32'(nmem_we), 0);
        @(negedge clk);
        check("t6_ack7", nack, 32'h80);
        check("t6_rdata7", nrdata, 8'h3C);
        @(posedge clk);
        #1 nreq = '0;

        // Randomized traffic against the behavioural model
        do_reset();
        for (int unsigned i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        for (int unsigned c = 0; c < N; c++) pend[c] = 1'b0;
        ptr_m = 0; exp_ack = '0; exp_rd = '0;
        for (int unsigned cyc = 0; cyc < 1500; cyc++) begin
            load = (cyc < 750) ? 1 : 3;
            @(posedge clk);
            #1;
            for (int unsigned c = 0; c < N; c++) begin
                if (!pend[c]) begin
                    if ($urandom_range(0, 3) < load) begin
                        pend[c] = 1'b1;
                        set_core(c, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
                    end else begin
                        req[c] = 1'b0;
                    end
                end
            end
            @(negedge clk);
            check("rnd_ack", ack, exp_ack);
            if (exp_ack != 0) check("rnd_rdata", rdata, exp_rd);
            found = 1'b0;
            w = 0;
            for (int unsigned k = 0; k < N; k++) begin
                if (!found && req[(ptr_m + k) % N] && !exp_ack[(ptr_m + k) % N]) begin
                    found = 1'b1;
                    w = (ptr_m + k) % N;
                end
            end
            for (int unsigned c = 0; c < N; c++) if (exp_ack[c]) pend[c] = 1'b0;
            if (found) begin
                a = addr[w*8 +: 8];
                phys = w * 32 + (a % 32);
                check("rnd_mem_addr", mem_addr, phys);
                check("rnd_mem_we", 32'(mem_we), 32'(we[w]));
                exp_rd = ref_mem[phys];
                if (we[w]) begin
                    check("rnd_mem_wdata", mem_wdata, wdata[w*8 +: 8]);
                    ref_mem[phys] = wdata[w*8 +: 8];
                end
                ptr_m = (w + 1) % N;
                exp_ack = 8'(1 << w);
            end else begin
                check("rnd_idle_we", 32'(mem_we), 0);
                exp_ack = '0;
            end
        end
        @(posedge clk);
        #1 req = '0;
        @(negedge clk);
        nz = 0;
        for (int unsigned i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nz++;
        check("rnd_mem_final", nz, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
